spi_monarch: RTL and testbench



---
 rtl/spi_monarch_if.sv | 23 ++
 rtl/spi_monarch.sv | 119 +++++++++++
 tb/tb_spi_monarch.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_monarch_if.sv
// Bus between an SPI monarch and the logic that issues its commands.
// The monarch side drives the serial pins and the result.
`timescale 1ns/1ps
interface spi_monarch_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rsp;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport master (
        input  wrt, cmd, MISO,
        output done, rsp, SS_n, SCLK, MOSI
    );

    modport slave (
        output wrt, cmd, MISO,
        input  done, rsp, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/spi_monarch.sv
// SPI mode-3 monarch for a 16-bit full-duplex exchange with an inertial sensor.
// SCLK = clk/32, with a front porch before the first fall and a back porch after the last sample.
`timescale 1ns/1ps
module spi_monarch (
    input  logic          clk,
    input  logic          rst_n,
    spi_monarch_if.master bus
);

    typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} state_t;

    localparam logic [4:0] DIV_LOAD = 5'b10111;

    state_t      state_reg, state_next;
    logic [4:0]  sclk_div_reg, sclk_div_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic        sample_reg, sample_next;
    logic [15:0] shft_reg, shft_next;
    logic        ss_n_reg, ss_n_next;
    logic        done_reg, done_next;
    logic        sclk_reg, sclk_next;

    logic div_wrap;
    logic div_rise;

    assign div_wrap = (sclk_div_reg == 5'b11111);
    assign div_rise = (sclk_div_reg == 5'b01111);

    always_comb begin
        state_next   = state_reg;
        shft_next    = shft_reg;
        bit_cnt_next = bit_cnt_reg;
        sample_next  = sample_reg;
        ss_n_next    = ss_n_reg;
        done_next    = done_reg;

        case (state_reg)
            IDLE: begin
                if (bus.wrt) begin
                    shft_next    = bus.cmd;
                    ss_n_next    = 1'b0;
                    done_next    = 1'b0;
                    bit_cnt_next = 4'd0;
                    state_next   = FRONT;
                end
            end
            FRONT: begin
                // The first SCLK fall only opens the window; nothing shifts yet.
                if (div_wrap) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (div_rise) begin
                    sample_next  = bus.MISO;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd15) begin
                        state_next = BACK;
                    end
                end
                if (div_wrap) begin
                    shft_next = {shft_reg[14:0], sample_reg};
                end
            end
            BACK: begin
                if (div_wrap) begin
                    shft_next  = {shft_reg[14:0], sample_reg};
                    ss_n_next  = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Divider is parked at its load value whenever the bus is idle or just going idle.
        if (state_reg == IDLE || state_next == IDLE) begin
            sclk_div_next = DIV_LOAD;
        end else begin
            sclk_div_next = sclk_div_reg + 5'd1;
        end

        sclk_next = 1'b1;
        if (state_next == FRONT || state_next == SHIFT) begin
            sclk_next = sclk_div_next[4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sclk_div_reg <= DIV_LOAD;
            bit_cnt_reg  <= 4'd0;
            sample_reg   <= 1'b0;
            shft_reg     <= 16'h0000;
            ss_n_reg     <= 1'b1;
            done_reg     <= 1'b0;
            sclk_reg     <= 1'b1;
        end else begin
            state_reg    <= state_next;
            sclk_div_reg <= sclk_div_next;
            bit_cnt_reg  <= bit_cnt_next;
            sample_reg   <= sample_next;
            shft_reg     <= shft_next;
            ss_n_reg     <= ss_n_next;
            done_reg     <= done_next;
            sclk_reg     <= sclk_next;
        end
    end

    assign bus.SS_n = ss_n_reg;
    assign bus.SCLK = sclk_reg;
    assign bus.MOSI = shft_reg[15];
    assign bus.done = done_reg;
    assign bus.rsp  = shft_reg;

endmodule

// File: tb/tb_spi_monarch.sv
// Directed bench for spi_monarch: loopback and sensor-model exchanges, edge timing,
// ignored re-requests, mid-transaction reset and back-to-back transactions.
`timescale 1ns/1ps
module tb_spi_monarch;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    spi_monarch_if bus();

    spi_monarch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        loopback = 1'b1;
    logic [15:0] slv_word = 16'h0000;
    logic [15:0] slv_seen = 16'h0000;
    logic [3:0]  slv_cnt = 4'd0;
    logic        miso_slave = 1'b0;

    assign bus.MISO = loopback ? bus.MOSI : miso_slave;

    // Sensor model: restarts on SS_n fall, presents the next bit on each SCLK fall.
    always @(negedge bus.SS_n or negedge bus.SCLK) begin
        if (bus.SCLK === 1'b1) begin
            slv_cnt <= 4'd0;
        end else if (bus.SS_n === 1'b0) begin
            miso_slave <= slv_word[4'd15 - slv_cnt];
            slv_cnt    <= slv_cnt + 4'd1;
        end
    end

    always @(posedge bus.SCLK) begin
        if (bus.SS_n === 1'b0) begin
            slv_seen <= {slv_seen[14:0], bus.MOSI};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Edge 0 is the clk edge that accepts wrt; e counts clk edges after it.
    task automatic run_txn(input string name, input logic [15:0] c, input logic [15:0] exp_rsp,
                           input bit loop, input logic [15:0] slv_w,
                           input int repulse_at, input int abort_at, input bit hold);
        int   n_rise, n_fall, first_fall, first_rise, last_rise, done_edge, bad_ss, bad_idle;
        logic prev_sclk, prev_ss;
        bit   aborted;
        n_rise = 0; n_fall = 0; first_fall = -1; first_rise = -1; last_rise = -1;
        done_edge = -1; bad_ss = 0; bad_idle = 0; aborted = 1'b0;
        loopback = loop;
        slv_word = slv_w;

        @(negedge clk);
        bus.cmd = c;
        bus.wrt = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.wrt = 1'b0;
        check_eq({name, ".accept_ss_n"}, {31'd0, bus.SS_n}, 32'd0);
        check_eq({name, ".accept_done"}, {31'd0, bus.done}, 32'd0);
        prev_sclk = bus.SCLK;
        prev_ss   = bus.SS_n;

        for (int e = 1; e <= 521 && !aborted; e++) begin
            if (e == repulse_at) begin
                bus.wrt = 1'b1;
                bus.cmd = 16'hFFFF;
            end
            @(posedge clk); #1;
            if (e == repulse_at && !hold) bus.wrt = 1'b0;
            if (e == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq({name, ".abort_ss_n"}, {31'd0, bus.SS_n}, 32'd1);
                check_eq({name, ".abort_sclk"}, {31'd0, bus.SCLK}, 32'd1);
                check_eq({name, ".abort_done"}, {31'd0, bus.done}, 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk); #1;
                    if (bus.done !== 1'b0 || bus.SS_n !== 1'b1 || bus.SCLK !== 1'b1) bad_idle++;
                end
                check_eq({name, ".quiet_after_abort"}, bad_idle, 32'd0);
                aborted = 1'b1;
            end else begin
                if (prev_sclk === 1'b1 && bus.SCLK === 1'b0) begin
                    n_fall++;
                    if (first_fall < 0) first_fall = e;
                end
                if (prev_sclk === 1'b0 && bus.SCLK === 1'b1) begin
                    n_rise++;
                    if (first_rise < 0) first_rise = e;
                    last_rise = e;
                end
                // The 17th fall point is the closing shift, where SCLK is held high and SS_n rises.
                if (prev_ss === 1'b0 && bus.SS_n === 1'b1) n_fall++;
                if (bus.SS_n === 1'b1 && bus.SCLK !== 1'b1) bad_idle++;
                if (e <= 520 && (bus.SS_n !== 1'b0 || bus.done !== 1'b0)) bad_ss++;
                if (bus.done === 1'b1 && done_edge < 0) done_edge = e;
                prev_sclk = bus.SCLK;
                prev_ss   = bus.SS_n;
            end
        end

        if (!aborted) begin
            check_eq({name, ".first_fall"}, first_fall, 32'd9);
            check_eq({name, ".first_rise"}, first_rise, 32'd25);
            check_eq({name, ".last_rise"},  last_rise,  32'd505);
            check_eq({name, ".n_rise"},     n_rise,     32'd16);
            check_eq({name, ".n_fall"},     n_fall,     32'd17);
            check_eq({name, ".done_edge"},  done_edge,  32'd521);
            check_eq({name, ".ss_low"},     bad_ss,     32'd0);
            check_eq({name, ".sclk_idle"},  bad_idle,   32'd0);
            check_eq({name, ".end_ss_n"},   {31'd0, bus.SS_n}, 32'd1);
            check_eq({name, ".rsp"},        {16'd0, bus.rsp},  {16'd0, exp_rsp});
            check_eq({name, ".mosi_bits"},  {16'd0, slv_seen}, {16'd0, c});
            $display("txn %s cmd=%04h rsp=%04h expected=%04h done_edge=%0d rises=%0d falls=%0d",
                     name, c, bus.rsp, exp_rsp, done_edge, n_rise, n_fall);
        end else begin
            $display("txn %s cmd=%04h aborted by reset at edge %0d", name, c, abort_at);
        end
    endtask

    initial begin
        bus.wrt = 1'b0;
        bus.cmd = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset.ss_n", {31'd0, bus.SS_n}, 32'd1);
        check_eq("reset.sclk", {31'd0, bus.SCLK}, 32'd1);
        check_eq("reset.done", {31'd0, bus.done}, 32'd0);
        check_eq("reset.rsp",  {16'd0, bus.rsp},  32'd0);
        check_eq("reset.mosi", {31'd0, bus.MOSI}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("idle.ss_n", {31'd0, bus.SS_n}, 32'd1);

        run_txn("loopback",    16'hA5C3, 16'hA5C3, 1'b1, 16'h0000, -1,  -1, 1'b0);
        run_txn("sensor",      16'h8F00, 16'h006A, 1'b0, 16'h006A, -1,  -1, 1'b0);
        run_txn("repulse",     16'h3C5A, 16'h3C5A, 1'b1, 16'h0000, 200, -1, 1'b0);
        run_txn("abort",       16'hA5C3, 16'hA5C3, 1'b1, 16'h0000, -1, 300, 1'b0);
        run_txn("after_abort", 16'h1234, 16'h1234, 1'b1, 16'h0000, -1,  -1, 1'b0);
        run_txn("b2b_first",   16'h0001, 16'h0001, 1'b1, 16'h0000, -1,  -1, 1'b1);
        run_txn("b2b_second",  16'h8000, 16'h8000, 1'b1, 16'h0000, -1,  -1, 1'b1);
        bus.wrt = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
